pi_stream_sequencer_water: RTL and testbench

- Initiator-side driver for the time-multiplexed PI integrator of the water/turbine control path.
- Holds one x word per turbine and launches one integration step on request.
- Issues the done_read_x pre-pulse, then sta, then streams the N x words on consecutive cycles.
- Captures the N returned y words framed by done_sig into a readable result bank, then reports completion or error.

---
 rtl/pi_stream_sequencer_water_pkg.sv | 31 +++
 rtl/pi_word_bank.sv | 68 ++++++
 rtl/pi_stream_sequencer_water.sv | 204 ++++++++++++++++++++
 tb/tb_pi_stream_sequencer_water.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pi_stream_sequencer_water_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pi_stream_sequencer_water_pkg
//  Description : Shared word width, turbine count, timing defaults and FSM
//                state encoding for the water-path PI stream sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
package pi_stream_sequencer_water_pkg;

    // float32 word width and default number of turbines per step
    localparam int SINGLE          = 32;
    localparam int N_WIND_TURBINE  = 3;

    // Default pre-pulse lead and sta-to-done_sig timeout
    localparam int LEAD_DEFAULT    = 15;
    localparam int TIMEOUT_DEFAULT = 64;

    // Sequencer states
    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_PRE     = 3'd1;
    localparam logic [2:0] ST_SEND    = 3'd2;
    localparam logic [2:0] ST_WAIT    = 3'd3;
    localparam logic [2:0] ST_COLLECT = 3'd4;

    // True when a bank index addresses one of the populated turbine slots
    function automatic logic idx_in_range(input int idx, input int depth);
        return idx < depth;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pi_word_bank.sv
`default_nettype none
// ============================================================================
//  Module      : pi_word_bank
//  Description : DEPTH x DW register file, synchronous write, synchronous
//                clear, single read port that is either registered
//                (1-cycle latency) or combinational. Indices >= DEPTH are
//                dropped on write and read back as 0.
//  Revision    : 1.0 - initial release
// ============================================================================
module pi_word_bank
    import pi_stream_sequencer_water_pkg::*;
#(
    parameter int DEPTH    = N_WIND_TURBINE,
    parameter int AW       = 6,
    parameter int DW       = SINGLE,
    parameter bit REG_READ = 1'b1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [DW-1:0] i_wdata,
    input  logic [AW-1:0] i_raddr,
    output logic [DW-1:0] o_rdata
);

    // Full 2**AW storage keeps indexing width-exact; only DEPTH slots are used
    localparam int SLOTS = 1 << AW;

    logic [DW-1:0] r_mem [SLOTS];
    logic          w_wr_ok;
    logic          w_rd_ok;

    assign w_wr_ok = i_we && idx_in_range(int'(i_waddr), DEPTH);
    assign w_rd_ok = idx_in_range(int'(i_raddr), DEPTH);

    // Storage: clear on reset, otherwise write the addressed in-range slot
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < SLOTS; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_wr_ok) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    generate
        if (REG_READ) begin : g_reg_rd
            logic [DW-1:0] r_rdata;

            // Registered read: a same-cycle write is seen only on the next read
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_rdata <= '0;
                end else begin
                    r_rdata <= w_rd_ok ? r_mem[i_raddr] : '0;
                end
            end

            assign o_rdata = r_rdata;
        end else begin : g_comb_rd
            assign o_rdata = w_rd_ok ? r_mem[i_raddr] : '0;
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/pi_stream_sequencer_water.sv
`default_nettype none
// ============================================================================
//  Module      : pi_stream_sequencer_water
//  Description : Initiator-side driver for the time-multiplexed PI
//                integrator. Emits done_read_x, then sta LEAD cycles later,
//                streams N x words, captures the N returned y words framed
//                by done_sig, and reports step_done / timeout / protocol error.
//  Revision    : 1.0 - initial release
// ============================================================================
module pi_stream_sequencer_water
    import pi_stream_sequencer_water_pkg::*;
#(
    parameter int N       = N_WIND_TURBINE,
    parameter int AW      = 6,
    parameter int LEAD    = LEAD_DEFAULT,
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_step_start,
    input  logic              i_wr_en,
    input  logic [AW-1:0]     i_wr_addr,
    input  logic [SINGLE-1:0] i_wr_data,
    output logic [SINGLE-1:0] o_x,
    output logic              o_sta,
    output logic              o_done_read_x,
    input  logic [SINGLE-1:0] i_y,
    input  logic              i_done_sig,
    input  logic [AW-1:0]     i_rd_addr,
    output logic [SINGLE-1:0] o_rd_data,
    output logic              o_busy,
    output logic              o_step_done,
    output logic              o_timeout_err,
    output logic              o_proto_err
);

    // Shared counter: LEAD count in PRE, then sta-relative timeout count
    localparam int CW = 16;

    logic [2:0]        r_state;
    logic [CW-1:0]     r_cnt;
    logic [AW-1:0]     r_k;
    logic [AW-1:0]     r_j;
    logic              r_rx_act;
    logic              r_busy;
    logic              r_drx;
    logic              r_step_done;
    logic              r_tout;
    logic              r_perr;

    logic              w_tx_on;
    logic              w_tx_last;
    logic              w_ds_ok;
    logic              w_ds_bad;
    logic              w_rx_we;
    logic [AW-1:0]     w_rx_idx;
    logic              w_rx_last;
    logic              w_tout;
    logic              w_in_we;
    logic [SINGLE-1:0] w_in_word;

    assign w_tx_on   = (r_state == ST_SEND);
    assign w_tx_last = w_tx_on && (int'(r_k) == N - 1);

    // done_sig opens a collection only once sta has gone out and none is running
    assign w_ds_ok   = i_done_sig && !r_rx_act &&
                       ((r_state == ST_SEND) || (r_state == ST_WAIT));
    assign w_ds_bad  = i_done_sig && !w_ds_ok;

    // Word j=0 is stored on the done_sig cycle itself, later words follow r_j
    assign w_rx_we   = w_ds_ok || r_rx_act;
    assign w_rx_idx  = w_ds_ok ? '0 : r_j;
    assign w_rx_last = w_rx_we && (int'(w_rx_idx) == N - 1);

    assign w_tout    = ((r_state == ST_SEND) || (r_state == ST_WAIT)) &&
                       !r_rx_act && !w_ds_ok && (int'(r_cnt) == TIMEOUT - 1);

    // The input bank is frozen while its words are being streamed
    assign w_in_we   = i_wr_en && !w_tx_on;

    assign o_x           = w_tx_on ? w_in_word : '0;
    assign o_sta         = w_tx_on && (r_k == '0);
    assign o_done_read_x = r_drx;
    assign o_busy        = r_busy;
    assign o_step_done   = r_step_done;
    assign o_timeout_err = r_tout;
    assign o_proto_err   = r_perr;

    pi_word_bank #(
        .DEPTH    (N),
        .AW       (AW),
        .DW       (SINGLE),
        .REG_READ (1'b0)
    ) u_in_bank (
        .clk     (clk),
        .rst     (rst),
        .i_we    (w_in_we),
        .i_waddr (i_wr_addr),
        .i_wdata (i_wr_data),
        .i_raddr (r_k),
        .o_rdata (w_in_word)
    );

    pi_word_bank #(
        .DEPTH    (N),
        .AW       (AW),
        .DW       (SINGLE),
        .REG_READ (1'b1)
    ) u_out_bank (
        .clk     (clk),
        .rst     (rst),
        .i_we    (w_rx_we),
        .i_waddr (w_rx_idx),
        .i_wdata (i_y),
        .i_raddr (i_rd_addr),
        .o_rdata (o_rd_data)
    );

    // Step sequencing, independent receive counter, completion and error flags
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_k         <= '0;
            r_j         <= '0;
            r_rx_act    <= 1'b0;
            r_busy      <= 1'b0;
            r_drx       <= 1'b0;
            r_step_done <= 1'b0;
            r_tout      <= 1'b0;
            r_perr      <= 1'b0;
        end else begin
            r_drx       <= 1'b0;
            r_step_done <= 1'b0;

            case (r_state)
                ST_IDLE: begin
                    if (i_step_start) begin
                        r_state <= ST_PRE;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                        r_tout  <= 1'b0;
                        r_perr  <= 1'b0;
                        r_drx   <= 1'b1;
                    end
                end
                ST_PRE: begin
                    if (int'(r_cnt) == LEAD - 1) begin
                        r_state <= ST_SEND;
                        r_cnt   <= '0;
                        r_k     <= '0;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                ST_SEND: begin
                    r_cnt <= r_cnt + CW'(1);
                    if (w_tx_last) begin
                        r_state <= (r_rx_act || w_ds_ok) ? ST_COLLECT : ST_WAIT;
                    end else begin
                        r_k <= r_k + AW'(1);
                    end
                end
                ST_WAIT: begin
                    r_cnt <= r_cnt + CW'(1);
                    if (w_ds_ok) begin
                        r_state <= ST_COLLECT;
                    end
                end
                default: begin
                end
            endcase

            if (w_ds_ok) begin
                r_rx_act <= 1'b1;
                r_j      <= AW'(1);
            end else if (r_rx_act) begin
                r_j <= r_j + AW'(1);
            end

            // done_sig cannot precede sta, so the last receive never ends
            // before the last transmit and completion can go straight to IDLE
            if (w_rx_last) begin
                r_rx_act    <= 1'b0;
                r_j         <= '0;
                r_state     <= ST_IDLE;
                r_busy      <= 1'b0;
                r_step_done <= 1'b1;
            end

            if (w_tout) begin
                r_state <= ST_IDLE;
                r_busy  <= 1'b0;
                r_tout  <= 1'b1;
            end

            if (w_ds_bad) begin
                r_perr <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pi_stream_sequencer_water.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pi_stream_sequencer_water
//  Description : Self-checking bench for pi_stream_sequencer_water with a
//                behavioural integrator returning y = x + 1.0.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pi_stream_sequencer_water;

    localparam int N       = 3;
    localparam int AW      = 6;
    localparam int LEAD    = 15;
    localparam int TIMEOUT = 64;
    localparam int SPAN    = LEAD + TIMEOUT + N + 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          i_step_start;
    logic          i_wr_en;
    logic [AW-1:0] i_wr_addr;
    logic [31:0]   i_wr_data;
    logic [31:0]   o_x;
    logic          o_sta;
    logic          o_done_read_x;
    logic [31:0]   i_y;
    logic          i_done_sig;
    logic [AW-1:0] i_rd_addr;
    logic [31:0]   o_rd_data;
    logic          o_busy;
    logic          o_step_done;
    logic          o_timeout_err;
    logic          o_proto_err;

    int            n_chk = 0;
    int            n_err = 0;

    int            iv [N];
    logic [31:0]   ib [N];
    logic [31:0]   ob [N];

    always #5 clk = ~clk;

    pi_stream_sequencer_water #(
        .N       (N),
        .AW      (AW),
        .LEAD    (LEAD),
        .TIMEOUT (TIMEOUT)
    ) u_dut (
        .clk           (clk),
        .rst           (rst),
        .i_step_start  (i_step_start),
        .i_wr_en       (i_wr_en),
        .i_wr_addr     (i_wr_addr),
        .i_wr_data     (i_wr_data),
        .o_x           (o_x),
        .o_sta         (o_sta),
        .o_done_read_x (o_done_read_x),
        .i_y           (i_y),
        .i_done_sig    (i_done_sig),
        .i_rd_addr     (i_rd_addr),
        .o_rd_data     (o_rd_data),
        .o_busy        (o_busy),
        .o_step_done   (o_step_done),
        .o_timeout_err (o_timeout_err),
        .o_proto_err   (o_proto_err)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
        end
    endtask

    // float32 <-> real for normal numbers (enough for integer-valued words)
    function automatic real f32_to_real(input logic [31:0] w);
        logic [10:0] e;
        e = {3'b000, w[30:23]} + 11'd896;
        return $bitstoreal({w[31], e, w[22:0], 29'd0});
    endfunction

    function automatic logic [31:0] real_to_f32(input real r);
        logic [63:0] b;
        logic [10:0] e;
        b = $realtobits(r);
        e = b[62:52] - 11'd896;
        return {b[63], e[7:0], b[51:29]};
    endfunction

    function automatic logic [31:0] int_to_f32(input int v);
        return real_to_f32(real'(v));
    endfunction

    // Integrator behaviour: y = x + 1.0
    function automatic logic [31:0] integ_y(input logic [31:0] x);
        return real_to_f32(f32_to_real(x) + 1.0);
    endfunction

    task automatic load(input bit directed);
        for (int i = 0; i < N; i++) begin
            iv[i] = directed ? (i + 1) : int'($urandom_range(1, 1000));
            ib[i] = int_to_f32(iv[i]);
            @(negedge clk);
            i_wr_en   = 1'b1;
            i_wr_addr = AW'(i);
            i_wr_data = ib[i];
        end
        @(negedge clk);
        i_wr_addr = AW'(N + int'($urandom_range(0, 2)));
        i_wr_data = $urandom;
        @(negedge clk);
        i_wr_en = 1'b0;
    endtask

    task automatic readback();
        int addrs [N + 2];
        for (int i = 0; i < N; i++) addrs[i] = i;
        addrs[N]     = N;
        addrs[N + 1] = (1 << AW) - 1;
        for (int i = 0; i < N + 2; i++) begin
            @(negedge clk);
            i_rd_addr = AW'(addrs[i]);
            @(negedge clk);
            check_eq("rd_data", o_rd_data, (addrs[i] < N) ? ob[addrs[i]] : 32'h0);
        end
    endtask

    task automatic run_step(input int lat, input bit integ_on, input bit spur_pre,
                            input bit dup_start, input bit wr_send, input bit rst_wait);
        int          sta_rel  = -1;
        int          done_rel = -1;
        int          tout_rel = -1;
        int          n_sta    = 0;
        int          n_dr     = 0;
        int          n_done   = 0;
        int          x_bad    = 0;
        int          exp_sta;
        int          exp_done;
        int          exp_tout;
        int          exp_end;
        int          rst_rel;
        logic [31:0] xs [$];

        exp_sta  = LEAD + 1;
        exp_done = (integ_on && !rst_wait) ? exp_sta + lat + N : -1;
        exp_tout = (!integ_on && !rst_wait) ? exp_sta + TIMEOUT : -1;
        exp_end  = (exp_done >= 0) ? exp_done : exp_tout;
        rst_rel  = exp_sta + N + 3;

        @(negedge clk);
        i_rd_addr    = '0;
        i_step_start = 1'b1;
        for (int rel = 1; rel <= SPAN; rel++) begin
            int k;
            int j;
            @(negedge clk);
            i_step_start = 1'b0;
            i_wr_en      = 1'b0;
            i_done_sig   = 1'b0;
            i_y          = $urandom;
            rst          = 1'b0;

            if (o_sta) begin
                n_sta++;
                if (sta_rel < 0) sta_rel = rel;
            end
            if (o_done_read_x) n_dr++;
            if (o_step_done) begin
                n_done++;
                if (done_rel < 0) done_rel = rel;
            end
            if (o_timeout_err && tout_rel < 0) tout_rel = rel;

            if (rel == 1) begin
                check_eq("busy_on_accept", 32'(o_busy), 32'd1);
                check_eq("drx_on_accept", 32'(o_done_read_x), 32'd1);
                check_eq("tout_cleared", 32'(o_timeout_err), 32'd0);
                check_eq("perr_cleared", 32'(o_proto_err), 32'd0);
            end

            k = rel - exp_sta;
            if (k >= 0 && k < N) begin
                check_eq("x_word", o_x, ib[k]);
            end else if (o_x !== 32'h0) begin
                x_bad++;
            end
            if (sta_rel >= 0 && rel - sta_rel < N) xs.push_back(o_x);

            if (exp_end >= 0 && rel == exp_end - 1) check_eq("busy_before_end", 32'(o_busy), 32'd1);
            if (exp_end >= 0 && rel == exp_end)     check_eq("busy_at_end", 32'(o_busy), 32'd0);

            if (rst_wait && rel == rst_rel + 1) begin
                check_eq("rst_busy", 32'(o_busy), 32'd0);
                check_eq("rst_sta", 32'(o_sta), 32'd0);
                check_eq("rst_drx", 32'(o_done_read_x), 32'd0);
                check_eq("rst_x", o_x, 32'h0);
                check_eq("rst_done", 32'(o_step_done), 32'd0);
                check_eq("rst_tout", 32'(o_timeout_err), 32'd0);
                check_eq("rst_perr", 32'(o_proto_err), 32'd0);
                check_eq("rst_rd", o_rd_data, 32'h0);
            end

            // Stimulus for this cycle
            if (rel == 2) begin
                iv[N-1]   = int'($urandom_range(1, 1000));
                ib[N-1]   = int_to_f32(iv[N-1]);
                i_wr_en   = 1'b1;
                i_wr_addr = AW'(N - 1);
                i_wr_data = ib[N-1];
            end
            if (dup_start && rel == 5) i_step_start = 1'b1;
            if (spur_pre && rel == 4) i_done_sig = 1'b1;
            if (wr_send && rel == exp_sta) begin
                i_wr_en   = 1'b1;
                i_wr_addr = AW'(1);
                i_wr_data = $urandom;
            end
            if (integ_on && sta_rel >= 0) begin
                j = rel - sta_rel - lat;
                if (j >= 0 && j < N) begin
                    i_done_sig = (j == 0);
                    i_y        = integ_y(xs[j]);
                end
            end
            if (rst_wait && rel == rst_rel) rst = 1'b1;
        end

        check_eq("sta_cycle", 32'(sta_rel), 32'(exp_sta));
        check_eq("sta_count", 32'(n_sta), 32'd1);
        check_eq("drx_count", 32'(n_dr), 32'd1);
        check_eq("done_cycle", 32'(done_rel), 32'(exp_done));
        check_eq("done_count", 32'(n_done), (exp_done >= 0) ? 32'd1 : 32'd0);
        check_eq("tout_cycle", 32'(tout_rel), 32'(exp_tout));
        check_eq("x_idle_zero", 32'(x_bad), 32'd0);
        check_eq("perr_final", 32'(o_proto_err), 32'(spur_pre));
        check_eq("busy_final", 32'(o_busy), 32'd0);

        if (exp_done >= 0) begin
            for (int i = 0; i < N; i++) ob[i] = int_to_f32(iv[i] + 1);
        end
        if (rst_wait) begin
            for (int i = 0; i < N; i++) begin
                ob[i] = 32'h0;
                ib[i] = 32'h0;
            end
        end
    endtask

    initial begin
        rst          = 1'b1;
        i_step_start = 1'b0;
        i_wr_en      = 1'b0;
        i_wr_addr    = '0;
        i_wr_data    = '0;
        i_y          = '0;
        i_done_sig   = 1'b0;
        i_rd_addr    = '0;
        for (int i = 0; i < N; i++) begin
            ob[i] = 32'h0;
            ib[i] = 32'h0;
            iv[i] = 0;
        end
        repeat (3) @(negedge clk);
        check_eq("reset_busy", 32'(o_busy), 32'd0);
        check_eq("reset_sta", 32'(o_sta), 32'd0);
        check_eq("reset_x", o_x, 32'h0);
        check_eq("reset_flags", {28'd0, o_done_read_x, o_step_done, o_timeout_err, o_proto_err}, 32'h0);
        check_eq("reset_rd", o_rd_data, 32'h0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Nominal step with 1.0/2.0/3.0, latency 20
        load(1'b1);
        run_step(20, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        readback();
        // No integrator response -> timeout
        load(1'b0);
        run_step(0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        readback();
        // Short latency, done_sig inside SEND
        load(1'b0);
        run_step(2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        readback();
        // Spurious done_sig in PRE
        load(1'b0);
        run_step(20, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        readback();
        // Repeated step_start while busy and write during SEND
        load(1'b0);
        run_step(int'($urandom_range(3, 30)), 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        readback();
        // Latest done_sig that still beats the timeout, and done_sig with sta
        load(1'b0);
        run_step(TIMEOUT - 1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        readback();
        load(1'b0);
        run_step(0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        readback();
        // Reset while waiting for done_sig
        load(1'b0);
        run_step(0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        readback();
        // Randomized steps
        repeat (4) begin
            load(1'b0);
            run_step(int'($urandom_range(0, TIMEOUT - 1)), 1'b1, 1'($urandom_range(0, 1)),
                     1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
            readback();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
